fp_addsub_gen: RTL and testbench

FP_ADDSUB_GEN -- requirements
Module: fp_addsub_gen

---
 rtl/fpu_pkg.sv | 11 +
 rtl/fp_lzc.sv | 14 +
 rtl/fp_addsub_gen.sv | 180 ++++++++++++++++++
 tb/tb_fp_addsub_gen.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FSM encoding, flag bit positions and canonical quiet-NaN pattern
package fpu_pkg;
  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_e;
  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;
  function automatic logic [127:0] qnan_bits(input int exp_w, input int man_w);
    return ((128'(1) << (exp_w + 1)) - 128'(1)) << (man_w - 1);
  endfunction
endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: combinational leading-zero counter, returns W for an all-zero input
module fp_lzc #(
  parameter int W = 27,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  d_i,
  output logic [CW-1:0] cnt_o
);
  // highest set bit wins because later iterations overwrite earlier ones
  always_comb begin
    cnt_o = CW'(W);
    for (int i = 0; i < W; i++) if (d_i[i]) cnt_o = CW'(W - 1 - i);
  end
endmodule

// File: rtl/fp_addsub_gen.sv
// fp_addsub_gen: multi-cycle IEEE-754 adder/subtractor with fixed six-cycle latency
module fp_addsub_gen
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ready,
  output logic         valid,
  output logic [W-1:0] c,
  output logic [3:0]   flags
);
  localparam int P = MAN_W + 1;
  localparam int X = MAN_W + 4;
  localparam int E = EXP_W + 1;
  localparam int LW = $clog2(X + 1);
  localparam logic [E-1:0] EMAX = E'((1 << EXP_W) - 1);
  localparam logic [W-1:0] QNAN = W'(qnan_bits(EXP_W, MAN_W));

  state_e state_q, state_d;
  logic [W-1:0] a_q, b_q, spc_q, res_q, c_q;
  logic op_q, sa_q, sb_q, sp_q, sgn_q, sub_q, valid_q;
  logic [E-1:0] ea_q, eb_q, ex_q;
  logic [P-1:0] ma_q, mb_q;
  logic [3:0] spf_q, resf_q, flags_q;
  logic [X-1:0] bx_q, sx_q, m_q;
  logic [X:0] sum_q;

  logic [EXP_W-1:0] fea, feb;
  logic [MAN_W-1:0] ffa, ffb;
  logic sbe, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan, inv, sp;
  logic [W-1:0] spc;
  logic [3:0] spf;
  assign fea = a_q[W-2:MAN_W];
  assign feb = b_q[W-2:MAN_W];
  assign ffa = a_q[MAN_W-1:0];
  assign ffb = b_q[MAN_W-1:0];
  assign sbe = b_q[W-1] ^ op_q;
  assign a_nan = (&fea) & (|ffa);
  assign b_nan = (&feb) & (|ffb);
  assign a_inf = (&fea) & ~(|ffa);
  assign b_inf = (&feb) & ~(|ffb);
  assign a_snan = a_nan & ~ffa[MAN_W-1];
  assign b_snan = b_nan & ~ffb[MAN_W-1];
  assign inv = a_snan | b_snan | (a_inf & b_inf & (a_q[W-1] ^ sbe));
  assign sp = a_nan | b_nan | a_inf | b_inf;
  assign spc = (a_nan | b_nan | inv) ? QNAN
             : a_inf ? {a_q[W-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}}
             : {sbe, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  assign spf = 4'(inv) << FLG_INV;

  logic a_big, lost;
  logic [E-1:0] e_hi, e_lo, diff;
  logic [P-1:0] m_hi, m_lo;
  logic [X-1:0] lo_ext, lo_sh;
  assign a_big = {ea_q, ma_q} >= {eb_q, mb_q};
  assign e_hi = a_big ? ea_q : eb_q;
  assign e_lo = a_big ? eb_q : ea_q;
  assign m_hi = a_big ? ma_q : mb_q;
  assign m_lo = a_big ? mb_q : ma_q;
  assign diff = e_hi - e_lo;
  assign lo_ext = {m_lo, 3'b000};
  assign lost = |(lo_ext & ~({X{1'b1}} << diff));
  assign lo_sh = (diff >= E'(MAN_W + 3)) ? X'(|m_lo) : (lo_ext >> diff) | X'(lost);

  logic [X:0] sum;
  assign sum = sub_q ? {1'b0, bx_q} - {1'b0, sx_q} : {1'b0, bx_q} + {1'b0, sx_q};

  logic [LW-1:0] lz;
  logic [E-1:0] lim, sh, e_nrm;
  logic [X-1:0] m_nrm;
  fp_lzc #(.W(X)) u_lzc (.d_i(sum_q[X-1:0]), .cnt_o(lz));
  assign lim = ex_q - E'(1);
  assign sh = (E'(lz) > lim) ? lim : E'(lz);
  assign m_nrm = sum_q[X] ? {sum_q[X:2], |sum_q[1:0]} : sum_q[X-1:0] << sh;
  assign e_nrm = sum_q[X] ? ex_q + E'(1) : ex_q - sh;

  logic up, ovf, inx, tiny;
  logic [P:0] rnd;
  logic [E-1:0] e_rnd;
  logic [W-1:0] res;
  logic [3:0] resf;
  assign up = m_q[2] & (m_q[1] | m_q[0] | m_q[3]);
  assign rnd = {1'b0, m_q[X-1:3]} + (P + 1)'(up);
  assign e_rnd = rnd[P] ? ex_q + E'(1) : ex_q;
  assign inx = |m_q[2:0];
  assign tiny = ~m_q[X-1];
  assign ovf = e_rnd >= EMAX;

  // pack the rounded result, saturating to signed infinity on overflow
  always_comb begin
    resf = '0;
    resf[FLG_OVF] = ovf;
    resf[FLG_UNF] = tiny & inx;
    resf[FLG_INX] = inx | ovf;
    res = ovf ? {sgn_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
        : {sgn_q, (rnd[P] | rnd[MAN_W]) ? e_rnd[EXP_W-1:0] : {EXP_W{1'b0}},
           rnd[P] ? {MAN_W{1'b0}} : rnd[MAN_W-1:0]};
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else state_q <= state_d;
  end

  // fixed walk through the stages; only IDLE waits for start
  always_comb begin
    state_d = state_q;
    ready = state_q == S_IDLE;
    unique case (state_q)
      S_IDLE:   state_d = start ? S_UNPACK : S_IDLE;
      S_UNPACK: state_d = S_ALIGN;
      S_ALIGN:  state_d = S_ADD;
      S_ADD:    state_d = S_NORM;
      S_NORM:   state_d = S_ROUND;
      S_ROUND:  state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // datapath registers, each stage loaded in its own FSM state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0; b_q <= '0; op_q <= 1'b0;
      sa_q <= 1'b0; sb_q <= 1'b0; ea_q <= '0; eb_q <= '0; ma_q <= '0; mb_q <= '0;
      sp_q <= 1'b0; spc_q <= '0; spf_q <= '0;
      sgn_q <= 1'b0; sub_q <= 1'b0; ex_q <= '0; bx_q <= '0; sx_q <= '0;
      sum_q <= '0; m_q <= '0; res_q <= '0; resf_q <= '0;
      c_q <= '0; flags_q <= '0; valid_q <= 1'b0;
    end else begin
      if (state_q == S_IDLE && start) begin
        a_q <= a; b_q <= b; op_q <= op;
      end
      if (state_q == S_UNPACK) begin
        sa_q <= a_q[W-1];
        sb_q <= sbe;
        ea_q <= {1'b0, (fea == '0) ? EXP_W'(1) : fea};
        eb_q <= {1'b0, (feb == '0) ? EXP_W'(1) : feb};
        ma_q <= {fea != '0, ffa};
        mb_q <= {feb != '0, ffb};
        sp_q <= sp; spc_q <= spc; spf_q <= spf;
      end
      if (state_q == S_ALIGN) begin
        sgn_q <= a_big ? sa_q : sb_q;
        sub_q <= sa_q ^ sb_q;
        ex_q <= e_hi;
        bx_q <= {m_hi, 3'b000};
        sx_q <= lo_sh;
      end
      if (state_q == S_ADD) begin
        sum_q <= sum;
        if (sub_q && sum == '0) sgn_q <= 1'b0;
      end
      if (state_q == S_NORM) begin
        m_q <= m_nrm; ex_q <= e_nrm;
      end
      if (state_q == S_ROUND) begin
        res_q <= sp_q ? spc_q : res;
        resf_q <= sp_q ? spf_q : resf;
      end
      if (state_q == S_DONE) begin
        c_q <= res_q; flags_q <= resf_q;
      end
      valid_q <= state_q == S_DONE;
    end
  end

  assign valid = valid_q;
  assign c = c_q;
  assign flags = flags_q;
endmodule

// File: tb/tb_fp_addsub_gen.sv
// tb_fp_addsub_gen: directed-vector self-checking bench for fp_addsub_gen
module tb_fp_addsub_gen;
  logic clk = 1'b0;
  logic rst, start, op, ready, valid;
  logic [31:0] a, b, c;
  logic [3:0] flags;
  int total = 0;
  int bad = 0;

  typedef struct packed { logic o; logic [31:0] x; logic [31:0] y; logic [31:0] r; logic [3:0] f; } vec_t;
  vec_t vt [16];

  fp_addsub_gen #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .ready(ready), .valid(valid), .c(c), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic launch(input logic o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = ~o; a = ~x; b = ~y;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!valid && n < 20);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk); #1;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
    total++; if (c !== 32'h0) begin bad++; $display("FAIL reset_c got=%h exp=00000000", c); end
    total++; if (flags !== 4'h0) begin bad++; $display("FAIL reset_flags got=%b exp=0000", flags); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_add();
    int n;
    launch(1'b0, 32'h3F800000, 32'h40000000);
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL add_busy got=%b exp=0", ready); end
    wait_valid(n);
    total++; if (n !== 6) begin bad++; $display("FAIL add_latency got=%0d exp=6", n); end
    total++; if (c !== 32'h40400000) begin bad++; $display("FAIL add_c got=%h exp=40400000", c); end
    total++; if (flags !== 4'h0) begin bad++; $display("FAIL add_flags got=%b exp=0000", flags); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL add_ready got=%b exp=1", ready); end
    @(posedge clk); #1;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL add_pulse got=%b exp=0", valid); end
  endtask

  task automatic test_vectors();
    int n;
    vt = '{
      '{1'b0, 32'h3F800000, 32'h33800000, 32'h3F800000, 4'b0001},
      '{1'b1, 32'h3F800000, 32'h3F800000, 32'h00000000, 4'b0000},
      '{1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 4'b0101},
      '{1'b1, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b1000},
      '{1'b1, 32'h00800000, 32'h00400000, 32'h00400000, 4'b0000},
      '{1'b0, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000},
      '{1'b0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000},
      '{1'b0, 32'h7F800000, 32'h3F800000, 32'h7F800000, 4'b0000},
      '{1'b1, 32'h3F800000, 32'h7F800000, 32'hFF800000, 4'b0000},
      '{1'b0, 32'h80000000, 32'h80000000, 32'h80000000, 4'b0000},
      '{1'b1, 32'h3F800000, 32'h40000000, 32'hBF800000, 4'b0000},
      '{1'b0, 32'h3F800000, 32'h33800001, 32'h3F800001, 4'b0001},
      '{1'b0, 32'h3F800001, 32'h33800000, 32'h3F800002, 4'b0001},
      '{1'b0, 32'h3FFFFFFF, 32'h33800000, 32'h40000000, 4'b0001},
      '{1'b1, 32'h80000000, 32'h00000000, 32'h80000000, 4'b0000},
      '{1'b0, 32'h80000000, 32'h00000000, 32'h00000000, 4'b0000}
    };
    for (int i = 0; i < 16; i++) begin
      launch(vt[i].o, vt[i].x, vt[i].y);
      wait_valid(n);
      total++; if (n !== 6) begin bad++; $display("FAIL vec%0d_latency got=%0d exp=6", i, n); end
      total++; if (c !== vt[i].r) begin bad++; $display("FAIL vec%0d_c got=%h exp=%h", i, c, vt[i].r); end
      total++; if (flags !== vt[i].f) begin bad++; $display("FAIL vec%0d_flags got=%b exp=%b", i, flags, vt[i].f); end
    end
  endtask

  task automatic test_ignored_start();
    int n, extra;
    launch(1'b0, 32'h3F800000, 32'h40000000);
    @(posedge clk); #1;
    start = 1'b1; op = 1'b0; a = 32'h7F800000; b = 32'h3F800000;
    @(posedge clk); #1;
    start = 1'b0;
    n = 2;
    do begin @(posedge clk); #1; n++; end while (!valid && n < 20);
    total++; if (n !== 6) begin bad++; $display("FAIL ign_latency got=%0d exp=6", n); end
    total++; if (c !== 32'h40400000) begin bad++; $display("FAIL ign_c got=%h exp=40400000", c); end
    extra = 0;
    repeat (12) begin @(posedge clk); #1; if (valid) extra++; end
    total++; if (extra !== 0) begin bad++; $display("FAIL ign_extra_valid got=%0d exp=0", extra); end
  endtask

  task automatic test_back_to_back();
    int n;
    launch(1'b0, 32'h3F800000, 32'h40000000);
    wait_valid(n);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b exp=1", ready); end
    start = 1'b1; op = 1'b0; a = 32'h40400000; b = 32'h3F800000;
    @(posedge clk); #1;
    start = 1'b0; a = '0; b = '0; op = 1'b1;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL b2b_accept got=%b exp=0", ready); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL b2b_pulse got=%b exp=0", valid); end
    wait_valid(n);
    total++; if (n !== 6) begin bad++; $display("FAIL b2b_latency got=%0d exp=6", n); end
    total++; if (c !== 32'h40800000) begin bad++; $display("FAIL b2b_c got=%h exp=40800000", c); end
  endtask

  task automatic test_rst_abort();
    int n, seen;
    launch(1'b0, 32'h3F800000, 32'h3F800000);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b exp=1", ready); end
    total++; if (c !== 32'h0) begin bad++; $display("FAIL abort_c got=%h exp=00000000", c); end
    total++; if (flags !== 4'h0) begin bad++; $display("FAIL abort_flags got=%b exp=0000", flags); end
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (10) begin @(posedge clk); #1; if (valid) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL abort_valid got=%0d exp=0", seen); end
    launch(1'b1, 32'h40000000, 32'h3F800000);
    wait_valid(n);
    total++; if (n !== 6) begin bad++; $display("FAIL abort_next_latency got=%0d exp=6", n); end
    total++; if (c !== 32'h3F800000) begin bad++; $display("FAIL abort_next_c got=%h exp=3F800000", c); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_vectors();
    test_ignored_start();
    test_back_to_back();
    test_rst_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
